// File: rtl/vga_bounce_box_pkg.sv
// vga_bounce_box_pkg
//   Types, widths and the palette lookup shared by the bouncing-box
//   renderer (vga_bounce_box) and its per-axis motion block (vga_box_axis).
package vga_bounce_box_pkg;

  `include "vga_params.vh"

  localparam int COORD_W = 10;  // pixel coordinate / box position width
  localparam int POS_W   = 11;  // one extra bit so pos+STEP and pos+BOX_SIZE never wrap

  // Coordinate value the timing generator presents outside the active area.
  localparam logic [COORD_W-1:0] COORD_OFF = 10'h3FF;

  typedef logic [15:0] rgb565_t;

  // Direction of travel along one axis.
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  function automatic rgb565_t palette_color(input logic [2:0] idx);
    rgb565_t c;
    case (idx)
      3'd0:    c = VGA_PAL_RED;
      3'd1:    c = VGA_PAL_GREEN;
      3'd2:    c = VGA_PAL_BLUE;
      3'd3:    c = VGA_PAL_YELLOW;
      3'd4:    c = VGA_PAL_CYAN;
      3'd5:    c = VGA_PAL_MAGENTA;
      3'd6:    c = VGA_PAL_WHITE;
      default: c = VGA_PAL_ORANGE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_box_axis.sv
// vga_box_axis
//   Position and direction of the box along one axis. On each tick with
//   en high the position advances by STEP in the current direction; hitting
//   either wall clamps the position to the wall, reverses direction and
//   raises hit for that tick cycle.
//
// Ports
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset (pos = 0, direction = +)
//   tick   : one-cycle frame pulse; the only time the position may change
//   en     : motion enable, sampled together with tick
//   pos    : current box position along this axis (0..LIMIT)
//   hit    : combinational, high during the tick cycle that hits a wall
module vga_box_axis
  import vga_bounce_box_pkg::*;
#(
  parameter int LIMIT = 608,
  parameter int STEP  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               en,
  output logic [COORD_W-1:0] pos,
  output logic               hit
);

  localparam logic [POS_W-1:0] LIMIT_W = POS_W'(LIMIT);
  localparam logic [POS_W-1:0] STEP_W  = POS_W'(STEP);

  logic [COORD_W-1:0] pos_reg, pos_next;
  dir_e               dir_reg, dir_next;
  logic               hit_next;
  logic [POS_W-1:0]   pos_wide;
  logic [POS_W-1:0]   pos_plus;
  logic [POS_W-1:0]   pos_minus;

  assign pos_wide  = {1'b0, pos_reg};
  assign pos_plus  = pos_wide + STEP_W;
  assign pos_minus = pos_wide - STEP_W;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_reg <= '0;
      dir_reg <= DIR_POS;
    end else begin
      pos_reg <= pos_next;
      dir_reg <= dir_next;
    end
  end

  // Next-state logic. The decrement compare uses <= so a step that would
  // land exactly on 0 is also treated as a wall hit.
  always_comb begin
    pos_next = pos_reg;
    dir_next = dir_reg;
    hit_next = 1'b0;
    if (tick && en) begin
      case (dir_reg)
        DIR_POS: begin
          if (pos_plus >= LIMIT_W) begin
            pos_next = LIMIT_W[COORD_W-1:0];
            dir_next = DIR_NEG;
            hit_next = 1'b1;
          end else begin
            pos_next = pos_plus[COORD_W-1:0];
          end
        end
        default: begin
          if (pos_wide <= STEP_W) begin
            pos_next = '0;
            dir_next = DIR_POS;
            hit_next = 1'b1;
          end else begin
            pos_next = pos_minus[COORD_W-1:0];
          end
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    pos = pos_reg;
    hit = hit_next;
  end

endmodule

// File: rtl/vga_params.vh
// Shared VGA constants: visible-area geometry and the 8-entry RGB565
// palette. Included inside the scope that needs them (package or module),
// so it carries declarations only and no include guard: each including
// scope gets its own copy.
localparam int VGA_H_VALID = 640;
localparam int VGA_V_VALID = 480;

localparam logic [15:0] VGA_PAL_RED     = 16'hF800;
localparam logic [15:0] VGA_PAL_GREEN   = 16'h07E0;
localparam logic [15:0] VGA_PAL_BLUE    = 16'h001F;
localparam logic [15:0] VGA_PAL_YELLOW  = 16'hFFE0;
localparam logic [15:0] VGA_PAL_CYAN    = 16'h07FF;
localparam logic [15:0] VGA_PAL_MAGENTA = 16'hF81F;
localparam logic [15:0] VGA_PAL_WHITE   = 16'hFFFF;
localparam logic [15:0] VGA_PAL_ORANGE  = 16'hFD20;

// File: rtl/vga_bounce_box.sv
// vga_bounce_box
//   Draws a BOX_SIZE x BOX_SIZE square that bounces around the visible area,
//   moving STEP pixels per axis once per frame and changing colour on every
//   wall hit. Pixel output is registered (one cycle after the coordinate).
//
// Ports
//   vga_clk   : pixel clock
//   sys_rst_n : asynchronous active-low reset
//   pix_x     : current column (0..H_VALID-1, 10'h3FF outside active area)
//   pix_y     : current row    (0..V_VALID-1, 10'h3FF outside active area)
//   move_en   : level; box moves at a frame boundary only while high
//   pix_data  : RGB565 colour for the coordinate presented one cycle earlier
//   bounce    : one-cycle pulse after a frame update that hit any wall
module vga_bounce_box
  import vga_bounce_box_pkg::*;
#(
  parameter int          H_VALID  = VGA_H_VALID,
  parameter int          V_VALID  = VGA_V_VALID,
  parameter int          BOX_SIZE = 32,
  parameter int          STEP     = 2,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               move_en,
  output logic [15:0]        pix_data,
  output logic               bounce
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_VALID - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_VALID - 1);
  localparam logic [POS_W-1:0]   BOX_W  = POS_W'(BOX_SIZE);

  logic               frame_tick_reg;
  logic               bounce_reg;
  logic [2:0]         color_idx_reg;
  rgb565_t            pix_data_reg;

  logic [COORD_W-1:0] pix_coord [2];
  logic [COORD_W-1:0] box_pos   [2];
  logic [1:0]         hit_vec;
  logic [1:0]         axis_inside;
  logic               any_hit;
  logic               in_box;

  assign pix_coord[0] = pix_x;
  assign pix_coord[1] = pix_y;

  // Axis 0 is X (limited by the line width), axis 1 is Y (frame height).
  // Both see the same registered frame tick, so the box only moves after
  // the last visible pixel, i.e. during blanking.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int AXIS_LIMIT = (gi == 0) ? (H_VALID - BOX_SIZE) : (V_VALID - BOX_SIZE);

      vga_box_axis #(
        .LIMIT (AXIS_LIMIT),
        .STEP  (STEP)
      ) u_axis (
        .clk   (vga_clk),
        .rst_n (sys_rst_n),
        .tick  (frame_tick_reg),
        .en    (move_en),
        .pos   (box_pos[gi]),
        .hit   (hit_vec[gi])
      );

      // Widened compare so box_pos + BOX_SIZE cannot wrap; the off-screen
      // marker is excluded explicitly rather than relying on its magnitude.
      assign axis_inside[gi] = (pix_coord[gi] != COORD_OFF)
                            && ({1'b0, pix_coord[gi]} >= {1'b0, box_pos[gi]})
                            && ({1'b0, pix_coord[gi]} <  ({1'b0, box_pos[gi]} + BOX_W));
    end
  endgenerate

  // A corner (both axes at once) still counts as a single hit.
  assign any_hit = |hit_vec;
  assign in_box  = &axis_inside;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_tick_reg <= 1'b0;
      bounce_reg     <= 1'b0;
      color_idx_reg  <= '0;
      pix_data_reg   <= '0;
    end else begin
      frame_tick_reg <= (pix_x == H_LAST) && (pix_y == V_LAST);
      bounce_reg     <= any_hit;
      if (any_hit) begin
        color_idx_reg <= color_idx_reg + 3'd1;
      end
      pix_data_reg   <= in_box ? palette_color(color_idx_reg) : BG_COLOR;
    end
  end

  assign pix_data = pix_data_reg;
  assign bounce   = bounce_reg;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Testbench for vga_bounce_box: a full-size instance (640x480) and a small
// 64x64 instance run side by side. The driver presents compressed "frames"
// (frame-end coordinate, a blanking cycle, then a few pixel probes), updates
// a reference model of the box and queues the expected pix_data/bounce for
// every cycle; a monitor pops and compares one entry per DUT per clock.
module tb_vga_bounce_box;

  localparam int          NDUT = 2;
  localparam int          BOX  = 32;
  localparam int          STEP = 2;
  localparam logic [15:0] BG   = 16'h0000;
  localparam int          OFF  = 1023;

  int          h_valid [NDUT] = '{640, 64};
  int          v_valid [NDUT] = '{480, 64};
  logic [15:0] pal     [8]    = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
                                  16'h07FF, 16'hF81F, 16'hFFFF, 16'hFD20};

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        move_en = 1'b0;
  logic [9:0]  px0 = 10'h3FF, py0 = 10'h3FF, px1 = 10'h3FF, py1 = 10'h3FF;
  logic [15:0] pd0, pd1;
  logic        b0, b1;

  always #5 clk = ~clk;

  vga_bounce_box dut_main (
    .vga_clk   (clk),
    .sys_rst_n (rst_n),
    .pix_x     (px0),
    .pix_y     (py0),
    .move_en   (move_en),
    .pix_data  (pd0),
    .bounce    (b0)
  );

  vga_bounce_box #(
    .H_VALID  (64),
    .V_VALID  (64),
    .BOX_SIZE (32)
  ) dut_small (
    .vga_clk   (clk),
    .sys_rst_n (rst_n),
    .pix_x     (px1),
    .pix_y     (py1),
    .move_en   (move_en),
    .pix_data  (pd1),
    .bounce    (b1)
  );

  typedef struct packed {
    logic [15:0] pix;
    logic        bounce;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: box corner, direction (+1/-1), colour index, and a
  // flag meaning "a frame end was presented last cycle, move on this one".
  int bx [NDUT], by [NDUT], dx [NDUT], dy [NDUT], col [NDUT];
  bit pend [NDUT];

  task automatic model_reset(input int d);
    bx[d] = 0; by[d] = 0; dx[d] = 1; dy[d] = 1; col[d] = 0; pend[d] = 0;
  endtask

  function automatic logic [15:0] model_pix(input int d, input int x, input int y);
    if (x >= h_valid[d] || y >= v_valid[d]) return BG;
    if (x >= bx[d] && x < bx[d] + BOX && y >= by[d] && y < by[d] + BOX) return pal[col[d]];
    return BG;
  endfunction

  // Bounce rule for one axis: clamp to the wall, reverse, report the hit.
  task automatic axis_move(input int lim, input int p_in, input int d_in,
                           output int p_out, output int d_out, output bit hit);
    hit = 0; p_out = p_in; d_out = d_in;
    if (d_in > 0) begin
      if (p_in + STEP >= lim) begin p_out = lim; d_out = -1; hit = 1; end
      else p_out = p_in + STEP;
    end else begin
      if (p_in <= STEP) begin p_out = 0; d_out = 1; hit = 1; end
      else p_out = p_in - STEP;
    end
  endtask

  task automatic model_cycle(input int d, input bit rst_v, input bit en, input int x, input int y);
    exp_t e;
    int   nx, ny, ndx, ndy;
    bit   hx, hy;
    if (!rst_v) begin
      model_reset(d);
      e.pix = BG; e.bounce = 1'b0;
    end else begin
      e.pix = model_pix(d, x, y);   // pixel sees the box before this cycle's move
      e.bounce = 1'b0;
      if (pend[d]) begin
        pend[d] = 0;
        if (en) begin
          axis_move(h_valid[d] - BOX, bx[d], dx[d], nx, ndx, hx);
          axis_move(v_valid[d] - BOX, by[d], dy[d], ny, ndy, hy);
          bx[d] = nx; dx[d] = ndx; by[d] = ny; dy[d] = ndy;
          if (hx || hy) begin
            col[d]   = (col[d] + 1) % 8;
            e.bounce = 1'b1;
          end
        end
      end
      if (x == h_valid[d] - 1 && y == v_valid[d] - 1) pend[d] = 1;
    end
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input bit rst_v, input bit en, input int x0, input int y0,
                       input int x1, input int y1);
    @(negedge clk);
    rst_n   = rst_v;
    move_en = en;
    px0 = 10'(x0); py0 = 10'(y0);
    px1 = 10'(x1); py1 = 10'(y1);
    model_cycle(0, rst_v, en, x0, y0);
    model_cycle(1, rst_v, en, x1, y1);
  endtask

  function automatic bit pick_en(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return mode[0];
  endfunction

  // Probe kinds: 0 box top-left, 1 box bottom-right, 2 just outside the
  // box edge, other = random pixel (occasionally the off-screen marker).
  task automatic pick(input int d, input int kind, output int x, output int y);
    int hv, vv;
    hv = h_valid[d];
    vv = v_valid[d];
    case (kind)
      0: begin x = bx[d]; y = by[d]; end
      1: begin x = bx[d] + BOX - 1; y = by[d] + BOX - 1; end
      2: begin
        if ($urandom_range(0, 1) == 0) begin
          y = by[d] + int'($urandom_range(0, BOX - 1));
          x = (bx[d] + BOX < hv) ? bx[d] + BOX : bx[d] - 1;
        end else begin
          x = bx[d] + int'($urandom_range(0, BOX - 1));
          y = (by[d] + BOX < vv) ? by[d] + BOX : by[d] - 1;
        end
      end
      default: begin
        if ($urandom_range(0, 7) == 0) begin x = OFF; y = OFF; end
        else begin
          x = int'($urandom_range(0, hv - 1));
          y = int'($urandom_range(0, vv - 1));
        end
      end
    endcase
  endtask

  task automatic run_frame(input int mode);
    int x0, y0, x1, y1;
    drive(1'b1, pick_en(mode), h_valid[0] - 1, v_valid[0] - 1, h_valid[1] - 1, v_valid[1] - 1);
    drive(1'b1, pick_en(mode), OFF, OFF, OFF, OFF);
    for (int k = 0; k < 4; k++) begin
      pick(0, k, x0, y0);
      pick(1, k, x1, y1);
      drive(1'b1, pick_en(mode), x0, y0, x1, y1);
    end
  endtask

  task automatic check(input string name, input logic [15:0] got_p, input logic got_b, input exp_t e);
    vectors++;
    if (got_p !== e.pix || got_b !== e.bounce) begin
      miscompares++;
      $display("FAIL %s @%0t: pix_data=%h bounce=%b, required pix_data=%h bounce=%b",
               name, $time, got_p, got_b, e.pix, e.bounce);
    end
  endtask

  // Monitor: one expected entry per DUT per clock, sampled after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("main", pd0, b0, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("small", pd1, b1, e);
    end
  end

  initial begin
    int x0, y0, x1, y1;
    model_reset(0);
    model_reset(1);

    // Reset held for a few cycles with in-box coordinates: outputs must stay 0.
    repeat (3) drive(1'b0, 1'b0, 0, 0, 0, 0);

    // First visible pixel and an empty-background pixel after release.
    drive(1'b1, 1'b1, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 100, 100, 40, 40);

    // Steady motion: bottom wall at frame 224, right wall at frame 304,
    // first step back at 305; the small instance corners at frame 16.
    for (int f = 0; f < 305; f++) run_frame(1);

    // Motion disabled: box must hold, no bounces.
    for (int f = 0; f < 10; f++) run_frame(0);

    // move_en toggling every cycle; only its value on the update cycle counts.
    for (int f = 0; f < 60; f++) run_frame(2);

    // Asynchronous reset mid-frame, right after an in-box pixel was output.
    pick(0, 0, x0, y0);
    pick(1, 0, x1, y1);
    drive(1'b1, 1'b1, x0, y0, x1, y1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pd0 !== 16'h0000 || b0 !== 1'b0 || pd1 !== 16'h0000 || b1 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: pix_data main=%h small=%h bounce=%b%b, required 0000/0000/00",
               pd0, pd1, b0, b1);
    end
    repeat (2) drive(1'b0, 1'b1, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 0, 0, 0, 0);
    for (int f = 0; f < 20; f++) run_frame(1);

    // Let the last queued entries be compared, then confirm nothing is left.
    drive(1'b1, 1'b0, OFF, OFF, OFF, OFF);
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d entries left, required 0/0", q0.size(), q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
